// File: rtl/exec_rd_arb_pkg.sv
// rtl/exec_rd_arb_pkg.sv - shared execution-unit constants: requester ids, opcodes, arbiter states
package exec_rd_arb_pkg;

  localparam int EXEC_N_REQ = 5;

  localparam int REQ_CONV  = 0;
  localparam int REQ_POOL  = 1;
  localparam int REQ_ADD   = 2;
  localparam int REQ_REMAP = 3;
  localparam int REQ_FC    = 4;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_CONV  = 4'h1,
    OP_POOL  = 4'h2,
    OP_ADD   = 4'h3,
    OP_REMAP = 4'h4,
    OP_FC    = 4'h5
  } exec_opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_ISSUE = 2'd2
  } arb_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exec_rd_arb_idfifo.sv
// rtl/exec_rd_arb_idfifo.sv - in-order FIFO of requester ids for outstanding read bursts
module exec_rd_arb_idfifo
  import exec_rd_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [W-1:0]           push_data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + PTR_W'(1);
      if (pop_ok)  rd_q <= rd_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/exec_rd_arb.sv
// rtl/exec_rd_arb.sv - round-robin read-command arbiter with in-order response routing
module exec_rd_arb
  import exec_rd_arb_pkg::*;
#(
  parameter int N_REQ     = EXEC_N_REQ,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 8,
  parameter int DATA_W    = 512,
  parameter int OST_DEPTH = 4,
  parameter int ID_W      = id_width(N_REQ)
) (
  input  logic                    clk,
  input  logic                    sys_rst_n,
  input  logic [N_REQ-1:0]        req_vld,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*LEN_W-1:0]  req_len,
  output logic [N_REQ-1:0]        req_rdy,
  output logic                    cmd_vld,
  output logic [ADDR_W-1:0]       cmd_addr,
  output logic [LEN_W-1:0]        cmd_len,
  output logic [ID_W-1:0]         cmd_id,
  input  logic                    cmd_rdy,
  input  logic                    mem_vld,
  input  logic [DATA_W-1:0]       mem_data,
  input  logic                    mem_last,
  output logic                    mem_rdy,
  output logic [N_REQ-1:0]        rsp_vld,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_last,
  input  logic [N_REQ-1:0]        rsp_rdy,
  output logic [N_REQ*32-1:0]     grant_cnt
);

  localparam int CNT_W = $clog2(OST_DEPTH) + 1;

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, win, cmd_id_q, head;
  logic [ADDR_W-1:0] cmd_addr_q, sel_addr;
  logic [LEN_W-1:0] cmd_len_q, sel_len;
  logic [31:0]      gcnt_q [N_REQ];
  logic [CNT_W-1:0] ost_cnt;
  logic             any_vld, ost_full, grant, pop, fifo_full, fifo_empty;

  assign any_vld  = |req_vld;
  assign ost_full = fifo_full | (ost_cnt == CNT_W'(OST_DEPTH));
  assign grant    = (state_q == ST_ARB) && any_vld && !ost_full;

  // Lowest valid index above rr_ptr wins; otherwise wrap to the lowest at or below it.
  always_comb begin
    win = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req_vld[i] && (ID_W'(i) <= rr_ptr_q)) win = ID_W'(i);
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req_vld[i] && (ID_W'(i) > rr_ptr_q)) win = ID_W'(i);
  end

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == ID_W'(i)) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_len  = req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_vld) state_d = ST_ARB;
      ST_ARB:   if (!any_vld) state_d = ST_IDLE;
                else if (!ost_full) state_d = ST_ISSUE;
      ST_ISSUE: if (cmd_rdy) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_rdy = '0;
    if (grant) req_rdy[win] = 1'b1;
    cmd_vld = (state_q == ST_ISSUE);
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rr_ptr_q   <= ID_W'(N_REQ - 1);
      cmd_addr_q <= '0;
      cmd_len_q  <= '0;
      cmd_id_q   <= '0;
      for (int i = 0; i < N_REQ; i++) gcnt_q[i] <= '0;
    end else if (grant) begin
      rr_ptr_q   <= win;
      cmd_addr_q <= sel_addr;
      cmd_len_q  <= sel_len;
      cmd_id_q   <= win;
      for (int i = 0; i < N_REQ; i++)
        if (win == ID_W'(i)) gcnt_q[i] <= gcnt_q[i] + 32'd1;
    end
  end

  assign cmd_addr = cmd_addr_q;
  assign cmd_len  = cmd_len_q;
  assign cmd_id   = cmd_id_q;

  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
    assign grant_cnt[g*32 +: 32] = gcnt_q[g];
  end

  exec_rd_arb_idfifo #(
    .DEPTH (OST_DEPTH),
    .W     (ID_W)
  ) u_idfifo (
    .clk         (clk),
    .rst_n       (sys_rst_n),
    .push_i      (grant),
    .push_data_i (win),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (ost_cnt)
  );

  // Beats with no outstanding id are held off rather than forwarded.
  always_comb begin
    rsp_vld  = '0;
    rsp_data = '0;
    rsp_last = 1'b0;
    mem_rdy  = 1'b0;
    if (!fifo_empty) begin
      rsp_vld[head] = mem_vld;
      rsp_data      = mem_data;
      rsp_last      = mem_last;
      mem_rdy       = rsp_rdy[head];
    end
  end

  assign pop = mem_vld && mem_rdy && mem_last;

endmodule

// File: tb/tb_exec_rd_arb.sv
// tb/tb_exec_rd_arb.sv - scoreboard bench for exec_rd_arb
module tb_exec_rd_arb;
  import exec_rd_arb_pkg::*;

  localparam int N   = EXEC_N_REQ;
  localparam int AW  = 32;
  localparam int LW  = 8;
  localparam int DW  = 512;
  localparam int OST = 4;
  localparam int IDW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          sys_rst_n;
  logic [N-1:0]  req_vld, req_rdy, rsp_vld, rsp_rdy;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_len;
  logic          cmd_vld, cmd_rdy, mem_vld, mem_last, mem_rdy, rsp_last;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [IDW-1:0] cmd_id;
  logic [DW-1:0] mem_data, rsp_data;
  logic [N*32-1:0] grant_cnt;

  exec_rd_arb #(
    .N_REQ(N), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW), .OST_DEPTH(OST)
  ) dut (
    .clk(clk), .sys_rst_n(sys_rst_n),
    .req_vld(req_vld), .req_addr(req_addr), .req_len(req_len), .req_rdy(req_rdy),
    .cmd_vld(cmd_vld), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id), .cmd_rdy(cmd_rdy),
    .mem_vld(mem_vld), .mem_data(mem_data), .mem_last(mem_last), .mem_rdy(mem_rdy),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_rdy(rsp_rdy),
    .grant_cnt(grant_cnt)
  );

  typedef struct { logic [AW-1:0] addr; logic [LW-1:0] len; int id; } cmd_t;
  typedef struct { int id; logic [DW-1:0] data; logic last; } rsp_t;

  int   exp_grant_q[$];
  cmd_t exp_cmd_q[$];
  rsp_t exp_rsp_q[$];

  int checks = 0, passed = 0;
  int n_grants = 0, last_grant_cyc = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] mk_data(input int id, input int b);
    logic [31:0] w;
    w = 32'hD000_0000 | (id << 8) | b;
    return {16{w}};
  endfunction

  // Monitor: compares grants, issued commands and routed beats against the queues.
  always @(negedge clk) begin : mon
    int   w;
    cmd_t c;
    rsp_t r;
    if (req_rdy != '0) begin
      w = 0;
      for (int i = 0; i < N; i++) if (req_rdy[i]) w = i;
      check("grant_onehot", DW'($onehot(req_rdy)), DW'(1));
      if (exp_grant_q.size() == 0) check("unexpected_grant", DW'(req_rdy), DW'(0));
      else check("grant_order", DW'(w), DW'(exp_grant_q.pop_front()));
      n_grants++;
      last_grant_cyc = cyc;
    end
    if (cmd_vld && cmd_rdy) begin
      if (exp_cmd_q.size() == 0) check("unexpected_cmd", DW'(cmd_vld), DW'(0));
      else begin
        c = exp_cmd_q.pop_front();
        check("cmd_addr", DW'(cmd_addr), DW'(c.addr));
        check("cmd_len", DW'(cmd_len), DW'(c.len));
        check("cmd_id", DW'(cmd_id), DW'(c.id));
      end
    end
    if ((rsp_vld & rsp_rdy) != '0) begin
      w = 0;
      for (int i = 0; i < N; i++) if (rsp_vld[i]) w = i;
      check("rsp_onehot", DW'($onehot(rsp_vld)), DW'(1));
      if (exp_rsp_q.size() == 0) check("unexpected_rsp", DW'(rsp_vld), DW'(0));
      else begin
        r = exp_rsp_q.pop_front();
        check("rsp_id", DW'(w), DW'(r.id));
        check("rsp_data", rsp_data, r.data);
        check("rsp_last", DW'(rsp_last), DW'(r.last));
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    sys_rst_n = 1'b0;
    req_vld = '0; mem_vld = 1'b0; mem_last = 1'b0; mem_data = '0;
    cmd_rdy = 1'b1; rsp_rdy = '1;
    repeat (2) @(posedge clk);
    #1 sys_rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
    req_addr[i*AW +: AW] = a;
    req_len[i*LW +: LW]  = l;
  endtask

  task automatic expect_grant(input int w);
    cmd_t c;
    exp_grant_q.push_back(w);
    c.addr = req_addr[w*AW +: AW];
    c.len  = req_len[w*LW +: LW];
    c.id   = w;
    exp_cmd_q.push_back(c);
  endtask

  task automatic wait_grants(input int target);
    int i;
    i = 0;
    while (n_grants < target && i < 200) begin
      @(posedge clk); #1;
      i++;
    end
    check("grant_timeout", DW'(n_grants >= target), DW'(1));
  endtask

  task automatic send_burst(input int id, input int nb, input bit toggle);
    rsp_t r;
    bit   done, phase;
    int   guard;
    phase = 1'b0;
    for (int b = 0; b < nb; b++) begin
      r.id = id; r.data = mk_data(id, b); r.last = (b == nb - 1);
      exp_rsp_q.push_back(r);
      mem_vld = 1'b1; mem_data = r.data; mem_last = r.last;
      done = 1'b0; guard = 0;
      while (!done) begin
        if (toggle) begin
          rsp_rdy = {N{phase}};
          phase = ~phase;
        end
        @(negedge clk);
        if (toggle) check("mem_rdy_mirror", DW'(mem_rdy), DW'(rsp_rdy[id]));
        done = mem_rdy;
        @(posedge clk); #1;
        guard++;
        if (!done && guard > 50) begin
          check("beat_timeout", DW'(mem_rdy), DW'(1));
          done = 1'b1;
        end
      end
    end
    mem_vld = 1'b0; mem_last = 1'b0; mem_data = '0; rsp_rdy = '1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int g, comp;
    sys_rst_n = 1'b0;
    req_vld = '0; req_addr = '0; req_len = '0;
    cmd_rdy = 1'b1; rsp_rdy = '1;
    mem_vld = 1'b1; mem_last = 1'b1; mem_data = mk_data(7, 7);

    // Reset values, including a stray beat during reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_rdy", DW'(req_rdy), DW'(0));
    check("rst_cmd_vld", DW'(cmd_vld), DW'(0));
    check("rst_cmd_addr", DW'(cmd_addr), DW'(0));
    check("rst_cmd_len", DW'(cmd_len), DW'(0));
    check("rst_cmd_id", DW'(cmd_id), DW'(0));
    check("rst_mem_rdy", DW'(mem_rdy), DW'(0));
    check("rst_rsp_vld", DW'(rsp_vld), DW'(0));
    check("rst_grant_cnt", DW'(grant_cnt), DW'(0));
    @(posedge clk); #1;
    mem_vld = 1'b0; mem_last = 1'b0; mem_data = '0;
    sys_rst_n = 1'b1;

    // Single requester 2, 4-beat burst.
    set_req(2, 32'h1000, 8'd3);
    expect_grant(2);
    g = n_grants;
    req_vld = 5'b00100;
    wait_grants(g + 1);
    req_vld = '0;
    @(negedge clk);
    check("t1_cmd_vld", DW'(cmd_vld), DW'(1));
    check("t1_cmd_id", DW'(cmd_id), DW'(2));
    @(posedge clk); #1;
    send_burst(2, 4, 1'b0);
    @(negedge clk);
    check("t1_grant_cnt2", DW'(grant_cnt[2*32 +: 32]), DW'(1));

    // All requesters: order 0..3, stall at four outstanding, then 4 and 0.
    apply_reset();
    for (int i = 0; i < N; i++) set_req(i, 32'h4000 + i * 32'h100, 8'd0);
    g = n_grants;
    for (int w = 0; w < 4; w++) expect_grant(w);
    req_vld = '1;
    wait_grants(g + 4);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t3_stall_grants", DW'(n_grants - g), DW'(4));
    check("t3_stall_rdy", DW'(req_rdy), DW'(0));
    @(posedge clk); #1;
    expect_grant(4);
    send_burst(0, 1, 1'b0);
    comp = cyc;
    wait_grants(g + 5);
    check("t3_regrant_latency", DW'((last_grant_cyc - comp) <= 2), DW'(1));
    expect_grant(0);
    send_burst(1, 1, 1'b0);
    wait_grants(g + 6);
    req_vld = '0;
    send_burst(2, 1, 1'b0);
    send_burst(3, 1, 1'b0);
    send_burst(4, 1, 1'b0);
    send_burst(0, 1, 1'b0);
    @(negedge clk);
    check("t2_grant_cnt0", DW'(grant_cnt[0 +: 32]), DW'(2));
    check("t2_grant_cnt4", DW'(grant_cnt[4*32 +: 32]), DW'(1));

    // Command back-pressure: fields hold, no new grant.
    apply_reset();
    cmd_rdy = 1'b0;
    set_req(1, 32'h2040, 8'd1);
    set_req(3, 32'h20C0, 8'd3);
    expect_grant(1);
    g = n_grants;
    req_vld = 5'b01010;
    wait_grants(g + 1);
    req_vld = 5'b01000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t4_cmd_vld", DW'(cmd_vld), DW'(1));
      check("t4_cmd_addr", DW'(cmd_addr), DW'(32'h2040));
      check("t4_cmd_len", DW'(cmd_len), DW'(1));
      check("t4_cmd_id", DW'(cmd_id), DW'(1));
      check("t4_no_grant", DW'(req_rdy), DW'(0));
    end
    @(posedge clk); #1;
    cmd_rdy = 1'b1;
    expect_grant(3);
    wait_grants(g + 2);
    req_vld = '0;
    send_burst(1, 2, 1'b0);
    send_burst(3, 4, 1'b0);

    // Toggling response ready during an 8-beat burst.
    apply_reset();
    set_req(4, 32'h8000, 8'd7);
    expect_grant(4);
    g = n_grants;
    req_vld = 5'b10000;
    wait_grants(g + 1);
    req_vld = '0;
    send_burst(4, 8, 1'b1);

    // Reset with three bursts outstanding.
    apply_reset();
    for (int i = 0; i < 3; i++) set_req(i, 32'hC000 + i * 32'h40, 8'd2);
    for (int w = 0; w < 3; w++) expect_grant(w);
    g = n_grants;
    req_vld = 5'b00111;
    wait_grants(g + 3);
    req_vld = '0;
    repeat (4) @(posedge clk);
    #2 sys_rst_n = 1'b0;
    #1;
    check("t6_rst_cmd_vld", DW'(cmd_vld), DW'(0));
    check("t6_rst_cmd_addr", DW'(cmd_addr), DW'(0));
    check("t6_rst_req_rdy", DW'(req_rdy), DW'(0));
    check("t6_rst_mem_rdy", DW'(mem_rdy), DW'(0));
    check("t6_rst_grant_cnt", DW'(grant_cnt), DW'(0));
    @(posedge clk); #1;
    sys_rst_n = 1'b1;
    mem_vld = 1'b1; mem_data = mk_data(0, 0); mem_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t6_post_mem_rdy", DW'(mem_rdy), DW'(0));
      check("t6_post_rsp_vld", DW'(rsp_vld), DW'(0));
    end
    @(posedge clk); #1;
    mem_vld = 1'b0; mem_last = 1'b0; mem_data = '0;
    repeat (2) @(posedge clk);

    check("end_grant_q_empty", DW'(exp_grant_q.size()), DW'(0));
    check("end_cmd_q_empty", DW'(exp_cmd_q.size()), DW'(0));
    check("end_rsp_q_empty", DW'(exp_rsp_q.size()), DW'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
